// File: rtl/swo_byte_fifo.sv
// swo_byte_fifo: byte queue behind the SWO decoder. Turns byte-ready toggles into
// writes, buffers bytes for a valid/ready consumer, and counts bytes dropped when full.
// Ports: clk, rst (sync, active-low), byteAvail/completeByte (decoder side),
//   dataOut/dataValid/dataReady (consumer side), fifoLevel, overflow, dropCount, clrStats.
module swo_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byteAvail,
  input  logic [7:0]            completeByte,
  output logic [7:0]            dataOut,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic [DEPTH_LOG2:0]   fifoLevel,
  output logic                  overflow,
  output logic [15:0]           dropCount,
  input  logic                  clrStats
);

  localparam int ENTRIES = (1 << DEPTH_LOG2) - 1;
  localparam logic [DEPTH_LOG2-1:0] PMAX = DEPTH_LOG2'(ENTRIES - 1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  logic [7:0]            r_mem [0:ENTRIES-1];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2-1:0] r_memCnt;
  logic                  r_prevAvail;
  logic                  r_armed;
  logic [7:0]            r_dataOut;
  logic                  r_dataValid;
  logic                  r_overflow;
  logic [15:0]           r_dropCount;

  logic                  w_wr;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_drop;
  logic                  w_accept;
  logic                  w_memEmpty;
  logic                  w_bypass;
  logic                  w_memWr;
  logic                  w_memRd;
  logic [7:0]            w_head;
  logic [DEPTH_LOG2-1:0] w_memCntNxt;

  assign fifoLevel = {1'b0, r_memCnt} + {{DEPTH_LOG2{1'b0}}, r_dataValid};
  assign dataOut   = r_dataOut;
  assign dataValid = r_dataValid;
  assign overflow  = r_overflow;
  assign dropCount = r_dropCount;

  assign w_wr       = r_armed && (byteAvail != r_prevAvail);
  assign w_pop      = r_dataValid && dataReady;
  assign w_full     = (fifoLevel == LVL_FULL);
  assign w_drop     = w_wr && w_full && !w_pop;
  assign w_accept   = w_wr && !w_drop;
  assign w_memEmpty = (r_memCnt == '0);
  // Straight into the output register when it is (or is about to become) empty.
  assign w_bypass   = !r_dataValid || (w_pop && w_memEmpty);
  assign w_memWr    = w_accept && !w_bypass;
  assign w_memRd    = w_pop && !w_memEmpty;
  assign w_head     = r_mem[r_rdPtr];

  always_comb begin
    w_memCntNxt = r_memCnt;
    if (w_memWr && !w_memRd)
      w_memCntNxt = r_memCnt + 1'b1;
    else if (!w_memWr && w_memRd)
      w_memCntNxt = r_memCnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_memWr)
      r_mem[r_wrPtr] <= completeByte;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_memCnt    <= '0;
      r_prevAvail <= byteAvail;
      r_armed     <= 1'b0;
      r_dataOut   <= 8'h00;
      r_dataValid <= 1'b0;
      r_overflow  <= 1'b0;
      r_dropCount <= 16'h0000;
    end else begin
      r_prevAvail <= byteAvail;
      r_armed     <= 1'b1;
      r_memCnt    <= w_memCntNxt;
      if (w_memWr)
        r_wrPtr <= (r_wrPtr == PMAX) ? '0 : r_wrPtr + 1'b1;
      if (w_memRd)
        r_rdPtr <= (r_rdPtr == PMAX) ? '0 : r_rdPtr + 1'b1;
      if (w_memRd) begin
        r_dataOut   <= w_head;
        r_dataValid <= 1'b1;
      end else if (w_accept && w_bypass) begin
        r_dataOut   <= completeByte;
        r_dataValid <= 1'b1;
      end else if (w_pop) begin
        r_dataValid <= 1'b0;
      end
      // A drop coinciding with a clear survives as a single counted drop.
      if (clrStats) begin
        r_overflow  <= w_drop;
        r_dropCount <= w_drop ? 16'h0001 : 16'h0000;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropCount != 16'hFFFF)
          r_dropCount <= r_dropCount + 16'h0001;
      end
    end
  end

endmodule

// File: doc/swo_byte_fifo.md
# swo_byte_fifo

Byte buffer directly downstream of the Manchester SWO decoder. Converts the decoder's toggling byte-ready indicator into single write events, queues the decoded bytes in a small FIFO, and presents them to the packet layer above on a valid/ready handshake. Bytes that arrive while the buffer is full are dropped and counted, so the host can detect lost trace data.

## Interface
- DEPTH_LOG2, 4, total capacity is 2^DEPTH_LOG2 bytes, including the output register; legal range 2..8.
- clk  input  1  module clock, shared with the SWO decoder.
- rst  input  1  synchronous, active-low reset; the block is in reset while rst==0 at a clk rising edge.
- byteAvail  input  1  toggling byte-ready from the decoder; each change of level signals one new byte.
- completeByte  input  8  decoded byte; valid in the cycle in which byteAvail changes.
- dataOut  output  8  head byte; registered.
- dataValid  output  1  dataOut holds an unconsumed byte.
- dataReady  input  1  consumer accepts dataOut this cycle.
- fifoLevel  output  DEPTH_LOG2+1  bytes currently held, 0..2^DEPTH_LOG2.
- overflow  output  1  sticky; set when a byte has been dropped.
- dropCount  output  16  count of dropped bytes; saturates at 0xFFFF.
- clrStats  input  1  single-cycle request to clear overflow and dropCount.

## Operation
- Toggle detect: the block registers byteAvail into prevAvail. A write event occurs when byteAvail != prevAvail and armed==1.
- armed is cleared by reset and set at the first clock after reset. prevAvail loads byteAvail on every cycle, including the first, so the arbitrary level the decoder holds at reset never generates a write.
- Storage has two parts:
  - a circular memory of 2^DEPTH_LOG2−1 entries, with wrPtr and rdPtr (DEPTH_LOG2 bits each, wrapping modulo entries) and an occupancy count;
  - a single output register (dataOut, dataValid).
- Pop: when dataValid && dataReady, the consumer takes dataOut. At the same edge the register reloads from the memory head if memory is non-empty; otherwise dataValid falls.
- Write routing:
  - If the output register is empty, or is being popped this cycle and memory is empty, the write bypasses memory and loads the output register directly.
  - Otherwise the byte goes to memory at wrPtr.
- Full: fifoLevel == 2^DEPTH_LOG2. A write while full with no pop in the same cycle is dropped: overflow←1 and dropCount←dropCount+1 (saturating). A write while full with a pop in the same cycle is accepted and fifoLevel is unchanged.
- Empty: fifoLevel == 0 and dataValid == 0. A pop is impossible; dataReady is ignored.
- fifoLevel = memory occupancy + dataValid. It is updated every cycle as +1 (write accepted), −1 (pop), or 0 (both or neither).
- clrStats:
  - clears overflow and dropCount.
  - If a drop occurs in the same cycle, the result is overflow=1 and dropCount=1; the event is never lost.
- Byte order at dataOut is strictly the arrival order of the write events.

## Timing
- Reset values: dataOut=0x00, dataValid=0, fifoLevel=0, overflow=0, dropCount=0, pointers=0, armed=0. Memory contents are not reset.
- Latency: toggle seen in cycle N with the block empty gives dataValid=1 and dataOut=byte from cycle N+1.
- With one or more bytes already queued, a byte written in cycle N is visible once all earlier bytes are popped, at the earliest in the cycle after the preceding pop.
- Throughput: one write and one pop per cycle sustained. Back-to-back toggles on consecutive cycles are each a separate write.
- dataOut and dataValid do not change while dataValid=1 and dataReady=0.
- Reset mid-operation (rst=0 at an edge) discards all held bytes immediately. The first toggle after reset release is ignored only if it occurs in the very first cycle out of reset, when armed is still 0.

## Test plan
- Reset, then byteAvail held at 1 for 10 cycles → no write; dataValid=0 and fifoLevel=0 throughout.
- Toggles carrying 0x41, 0x42, 0x43 on consecutive cycles with dataReady=1 → dataOut shows 0x41, 0x42, 0x43 on cycles N+1..N+3; fifoLevel never exceeds 1.
- dataReady=0, 18 toggles carrying 0x00..0x11 with DEPTH_LOG2=4 → fifoLevel=16, overflow=1, dropCount=2. Draining then yields 0x00..0x0F in order, and fifoLevel returns to 0.
- Full FIFO plus a toggle and a pop in the same cycle → byte accepted, fifoLevel stays 16, dropCount unchanged.
- Full FIFO plus a drop and clrStats in the same cycle → overflow=1, dropCount=1; clrStats alone next cycle → overflow=0, dropCount=0.
- rst pulsed low with 5 bytes held → next cycle dataValid=0, fifoLevel=0; a subsequent toggle carrying 0x99 appears as the first byte.
